io_result_unloader: RTL and testbench

// - Transmit side of the IO interface: streams solver results from RAM back to the CPU over the 32-bit CPU_Bus.
// - Reads 64-bit RAM words, sends each as two 32-bit beats (low half first) under an INT-acknowledged handshake.
// - Sits beside IO_Module in ODE_Solver_Chip; uses one RAM read port; top level owns the CPU_Bus tristate.

---
 rtl/io_pkg.sv | 24 ++
 rtl/io_result_unloader.sv | 161 ++++++++++++++++
 tb/tb_io_result_unloader.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// ---------------------------------------------------------------------------
// io_pkg
// Shared definitions for the IO interface of the ODE solver chip.
// Holds the FSM state encodings of the result unloader, the CPU bus width
// and the beat-order constant that the loader side (IO_Module) also uses,
// so both directions agree on which half of a 64-bit word travels first.
// ---------------------------------------------------------------------------
package io_pkg;

    // Width of the CPU_Bus; one RAM word is two bus beats.
    localparam int BUS_WIDTH = 32;

    // 1 = low half of a RAM word goes over the bus first.
    localparam bit LO_FIRST = 1'b1;

    // Unloader FSM state encodings.
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_SEND_LO = 3'd3;
    localparam logic [2:0] S_SEND_HI = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

endpackage

// File: rtl/io_result_unloader.sv
// ---------------------------------------------------------------------------
// io_result_unloader
// Transmit side of the IO interface. Streams solver results out of RAM to
// the CPU: each 64-bit RAM word is read once and sent as two 32-bit beats,
// each beat held on the bus until the CPU acknowledges it with a one-cycle
// INT pulse. The top level owns the CPU_Bus tristate and drives it with
// o_busOut whenever o_busOe is high.
//
// Ports
//   i_clk            single clock, rising edge
//   i_rst            synchronous active-high reset
//   i_start          1-cycle pulse, honoured only while idle
//   i_baseAddress    first RAM word address, sampled with i_start
//   i_wordCount      number of 64-bit words to send, sampled with i_start
//   i_int            CPU acknowledge, 1-cycle pulse per consumed beat
//   o_ramRdAddress   RAM read address, only changes when a read is issued
//   i_ramRdData      RAM read data, valid one cycle after the address
//   o_busOut         registered beat data for CPU_Bus
//   o_busOe          top level drives CPU_Bus while high
//   o_beatValid      o_busOut holds a beat the CPU has not yet acked
//   o_busy           transfer in progress (every state except idle)
//   o_doneUnloading  1-cycle pulse once the last beat has been acked
// ---------------------------------------------------------------------------
module io_result_unloader
    import io_pkg::*;
#(
    parameter int RAM_ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH        = 64,
    parameter int BUS_WIDTH         = io_pkg::BUS_WIDTH
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic [RAM_ADDRESS_WIDTH-1:0] i_baseAddress,
    input  logic [RAM_ADDRESS_WIDTH-1:0] i_wordCount,
    input  logic                         i_int,
    output logic [RAM_ADDRESS_WIDTH-1:0] o_ramRdAddress,
    input  logic [DATA_WIDTH-1:0]        i_ramRdData,
    output logic [BUS_WIDTH-1:0]         o_busOut,
    output logic                         o_busOe,
    output logic                         o_beatValid,
    output logic                         o_busy,
    output logic                         o_doneUnloading
);

    logic [2:0]                   r_state;
    logic [2:0]                   w_nextState;
    logic [RAM_ADDRESS_WIDTH-1:0] r_addr;
    logic [RAM_ADDRESS_WIDTH-1:0] r_remaining;
    logic [RAM_ADDRESS_WIDTH-1:0] r_ramRdAddress;
    logic [DATA_WIDTH-1:0]        r_hold;
    logic [BUS_WIDTH-1:0]         r_busOut;
    logic                         r_done;

    logic                         w_lastWord;
    logic                         w_countZero;
    logic [RAM_ADDRESS_WIDTH-1:0] w_addrNext;
    logic [BUS_WIDTH-1:0]         w_firstHalfRam;
    logic [BUS_WIDTH-1:0]         w_secondHalfHold;

    // Beat ordering follows the shared LO_FIRST constant. The first beat is
    // taken straight from the RAM data port so it can be on the bus in the
    // same cycle the word lands in the holding register.
    assign w_firstHalfRam   = LO_FIRST ? i_ramRdData[BUS_WIDTH-1:0]
                                       : i_ramRdData[DATA_WIDTH-1:BUS_WIDTH];
    assign w_secondHalfHold = LO_FIRST ? r_hold[DATA_WIDTH-1:BUS_WIDTH]
                                       : r_hold[BUS_WIDTH-1:0];

    // Address arithmetic wraps silently at the top of the RAM.
    assign w_addrNext  = r_addr + {{(RAM_ADDRESS_WIDTH-1){1'b0}}, 1'b1};
    assign w_lastWord  = (r_remaining == {{(RAM_ADDRESS_WIDTH-1){1'b0}}, 1'b1});
    assign w_countZero = (i_wordCount == '0);

    // Next-state logic. INT is only meaningful while a beat is on the bus,
    // and Start only while idle, so every other state simply ignores them.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_nextState = w_countZero ? S_DONE : S_READ;
                end
            end
            S_READ:    w_nextState = S_WAIT;
            S_WAIT:    w_nextState = S_SEND_LO;
            S_SEND_LO: begin
                if (i_int) begin
                    w_nextState = S_SEND_HI;
                end
            end
            S_SEND_HI: begin
                if (i_int) begin
                    w_nextState = w_lastWord ? S_DONE : S_READ;
                end
            end
            S_DONE:    w_nextState = S_IDLE;
            default:   w_nextState = S_IDLE;
        endcase
    end

    // State, datapath and registered outputs. The read address is loaded on
    // the edge that enters READ, so the RAM sees it for exactly the READ
    // cycle and it holds its value for the rest of the transfer. The done
    // pulse is registered off the DONE state, which puts it one cycle after
    // DONE is reached (two cycles after Start for an empty transfer).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_remaining    <= '0;
            r_ramRdAddress <= '0;
            r_hold         <= '0;
            r_busOut       <= '0;
            r_done         <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_done  <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_addr      <= i_baseAddress;
                        r_remaining <= i_wordCount;
                        if (!w_countZero) begin
                            r_ramRdAddress <= i_baseAddress;
                        end
                    end
                end
                S_WAIT: begin
                    r_hold   <= i_ramRdData;
                    r_busOut <= w_firstHalfRam;
                end
                S_SEND_LO: begin
                    if (i_int) begin
                        r_busOut <= w_secondHalfHold;
                    end
                end
                S_SEND_HI: begin
                    if (i_int) begin
                        r_remaining <= r_remaining - {{(RAM_ADDRESS_WIDTH-1){1'b0}}, 1'b1};
                        r_addr      <= w_addrNext;
                        r_busOut    <= '0;
                        if (!w_lastWord) begin
                            r_ramRdAddress <= w_addrNext;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Bus enable and beat-valid are the same condition: a beat is on the bus.
    assign o_beatValid     = (r_state == S_SEND_LO) || (r_state == S_SEND_HI);
    assign o_busOe         = o_beatValid;
    assign o_busy          = (r_state != S_IDLE);
    assign o_busOut        = r_busOut;
    assign o_ramRdAddress  = r_ramRdAddress;
    assign o_doneUnloading = r_done;

endmodule

// File: tb/tb_io_result_unloader.sv
// ---------------------------------------------------------------------------
// tb_io_result_unloader
// Self-checking bench for io_result_unloader. A behavioural RAM feeds the
// DUT; the expected beat stream for every transfer is computed from the
// memory contents, base address and word count with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_io_result_unloader;

    localparam int AW = 13;
    localparam int DW = 64;
    localparam int BW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] baseAddress;
    logic [AW-1:0] wordCount;
    logic          intAck;
    logic [AW-1:0] ramRdAddress;
    logic [DW-1:0] ramRdData;
    logic [BW-1:0] busOut;
    logic          busOe;
    logic          beatValid;
    logic          busy;
    logic          doneUnloading;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;
    int doneCount = 0;
    int oeCount = 0;

    io_result_unloader #(
        .RAM_ADDRESS_WIDTH(AW),
        .DATA_WIDTH(DW),
        .BUS_WIDTH(BW)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_start(start),
        .i_baseAddress(baseAddress),
        .i_wordCount(wordCount),
        .i_int(intAck),
        .o_ramRdAddress(ramRdAddress),
        .i_ramRdData(ramRdData),
        .o_busOut(busOut),
        .o_busOe(busOe),
        .o_beatValid(beatValid),
        .o_busy(busy),
        .o_doneUnloading(doneUnloading)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: data appears one cycle after the address.
    always @(posedge clk) begin
        ramRdData <= mem[ramRdAddress];
    end

    // Count done pulses and bus-enable cycles away from the active edge.
    always @(negedge clk) begin
        if (doneUnloading === 1'b1) doneCount++;
        if (busOe === 1'b1) oeCount++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".ramRdAddress"}, 64'(ramRdAddress), 64'd0);
        checkOutput({tag, ".busOut"}, 64'(busOut), 64'd0);
        checkOutput({tag, ".busOe"}, 64'(busOe), 64'd0);
        checkOutput({tag, ".beatValid"}, 64'(beatValid), 64'd0);
        checkOutput({tag, ".busy"}, 64'(busy), 64'd0);
        checkOutput({tag, ".done"}, 64'(doneUnloading), 64'd0);
    endtask

    // Run one transfer. startAtBeat injects a stray Start while that beat
    // is on the bus; abortAtBeat asserts reset while that beat is on the bus.
    task automatic applyStimulus(input logic [AW-1:0] base, input logic [AW-1:0] count,
                                 input int maxDelay, input int startAtBeat,
                                 input int abortAtBeat);
        logic [BW-1:0] expBeats[$];
        logic [AW-1:0] expAddr[$];
        logic [AW-1:0] a;
        int doneBefore;
        int oeBefore;
        int waited;
        int delay;

        for (int i = 0; i < int'(count); i++) begin
            a = base + AW'(i);
            expAddr.push_back(a);
            expBeats.push_back(mem[a][31:0]);
            expBeats.push_back(mem[a][63:32]);
        end
        doneBefore = doneCount;
        oeBefore   = oeCount;

        start       = 1'b1;
        baseAddress = base;
        wordCount   = count;
        tick();
        start       = 1'b0;
        baseAddress = AW'($urandom);
        wordCount   = AW'($urandom);
        checkOutput("startBusy", 64'(busy), 64'd1);

        for (int b = 0; b < expBeats.size(); b++) begin
            waited = 0;
            while (beatValid !== 1'b1 && waited < 50) begin
                tick();
                waited++;
            end
            checkOutput("beatValid", 64'(beatValid), 64'd1);
            checkOutput("beatLatency", 64'(waited), (b % 2 == 0) ? 64'd2 : 64'd0);
            checkOutput("beatData", 64'(busOut), 64'(expBeats[b]));
            checkOutput("busOe", 64'(busOe), 64'd1);
            if (b % 2 == 0) begin
                checkOutput("ramAddr", 64'(ramRdAddress), 64'(expAddr[b / 2]));
            end
            if (b == abortAtBeat) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                checkAllZero("abort");
                repeat (4) tick();
                checkOutput("abortNoDone", 64'(doneCount - doneBefore), 64'd0);
                checkOutput("abortIdle", 64'(busy), 64'd0);
                return;
            end
            if (b == startAtBeat) begin
                start       = 1'b1;
                baseAddress = base + 13'd100;
                wordCount   = 13'd7;
                tick();
                start       = 1'b0;
                checkOutput("strayStartHold", 64'(busOut), 64'(expBeats[b]));
            end
            delay = $urandom_range(0, maxDelay);
            repeat (delay) begin
                tick();
                checkOutput("stableValid", 64'(beatValid), 64'd1);
                checkOutput("stableData", 64'(busOut), 64'(expBeats[b]));
            end
            intAck = 1'b1;
            tick();
            intAck = 1'b0;
        end

        // DONE state, then the registered done pulse, then idle.
        checkOutput("doneStateBusy", 64'(busy), 64'd1);
        checkOutput("doneStateOe", 64'(busOe), 64'd0);
        checkOutput("doneEarly", 64'(doneUnloading), 64'd0);
        tick();
        checkOutput("donePulse", 64'(doneUnloading), 64'd1);
        checkOutput("doneIdle", 64'(busy), 64'd0);
        tick();
        checkOutput("doneDrop", 64'(doneUnloading), 64'd0);
        checkOutput("doneCount", 64'(doneCount - doneBefore), 64'd1);
        if (count == 0) begin
            checkOutput("emptyNoOe", 64'(oeCount - oeBefore), 64'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = {$urandom, $urandom};
        end
        mem[13'h010] = 64'hDEADBEEF_01234567;

        rst         = 1'b1;
        start       = 1'b0;
        baseAddress = '0;
        wordCount   = '0;
        intAck      = 1'b0;
        repeat (3) tick();
        checkAllZero("reset");
        rst = 1'b0;
        tick();
        checkAllZero("postReset");

        $display("[TB] single word 0x010");
        applyStimulus(13'h010, 13'd1, 0, -1, -1);

        $display("[TB] three words with random ack delay");
        applyStimulus(13'h010, 13'd3, 20, -1, -1);

        $display("[TB] empty transfer");
        applyStimulus(13'h055, 13'd0, 0, -1, -1);

        $display("[TB] address wrap");
        applyStimulus(13'h1FFF, 13'd2, 3, -1, -1);

        $display("[TB] stray INT while idle");
        repeat (3) begin
            intAck = 1'b1;
            tick();
        end
        intAck = 1'b0;
        checkOutput("strayIntBusy", 64'(busy), 64'd0);
        checkOutput("strayIntOe", 64'(busOe), 64'd0);

        $display("[TB] second Start mid-transfer");
        applyStimulus(13'h0A0, 13'd2, 4, 1, -1);

        $display("[TB] Start and reset together");
        rst         = 1'b1;
        start       = 1'b1;
        baseAddress = 13'h020;
        wordCount   = 13'd2;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        tick();
        checkOutput("rstWinsBusy", 64'(busy), 64'd0);

        $display("[TB] reset during high beat of word 2 of 4");
        applyStimulus(13'h300, 13'd4, 5, -1, 3);

        $display("[TB] fresh transfer after reset");
        applyStimulus(13'h123, 13'd2, 6, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
